// File: rtl/conv_pkg.sv
// Shared definitions for the convolution window streamer: FSM state encoding,
// counter width helpers and the tap-to-bit-offset mapping of the window bus.
package conv_pkg;

  // FSM state encoding kept as plain constants for compatibility with legacy users.
  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StFill   = 2'd1;
  localparam state_t StStream = 2'd2;
  localparam state_t StFlush  = 2'd3;

  localparam int unsigned DefDataWidth  = 32;
  localparam int unsigned DefKernelSize = 3;
  localparam int unsigned DefMaxWidth   = 1024;

  // Width of a counter able to hold 0..max_width inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_width);
    return $clog2(max_width + 1);
  endfunction

  // Address width of a RAM with the given depth (at least one bit).
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned DefCntWidth = cnt_width(DefMaxWidth);

  // LSB of tap (r, c) in the flattened window; r = 0 is the top row, c = 0 the left column.
  function automatic int unsigned tap_lsb(input int unsigned r, input int unsigned c,
                                          input int unsigned k, input int unsigned dw);
    return (r * k + c) * dw;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image line of storage: a ring RAM indexed by column. The read is
// combinational so the previous-line pixel at a column is available in the same
// cycle that the new pixel for that column overwrites it.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned DEPTH      = DefMaxWidth,
  parameter int unsigned ADDR_WIDTH = addr_width(DefMaxWidth)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port: contents are never cleared, stale data is masked or discarded upstream.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

  assign rd_data = mem[addr];

endmodule

// File: rtl/conv_window_streamer.sv
// Sliding KxK window generator over a raster pixel stream.
// Build option: define CONV_WIN_ZERO_PAD_EN to emit one window centred on every
// pixel (odd KERNEL_SIZE only) with out-of-frame taps forced to zero; otherwise
// only fully in-frame windows are emitted.
module conv_window_streamer
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned KERNEL_SIZE = DefKernelSize,
  parameter int unsigned MAX_WIDTH   = DefMaxWidth
) (
  input  logic                                      axi_clk,
  input  logic                                      axi_reset_n,
  input  logic [cnt_width(MAX_WIDTH)-1:0]           cfg_width,
  input  logic [cnt_width(MAX_WIDTH)-1:0]           cfg_height,
  input  logic                                      cfg_start,
  input  logic                                      s_axis_valid,
  output logic                                      s_axis_ready,
  input  logic [DATA_WIDTH-1:0]                     s_axis_data,
  input  logic                                      s_axis_last,
  output logic                                      m_axis_valid,
  input  logic                                      m_axis_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] m_axis_window,
  output logic                                      m_axis_last,
  output logic                                      busy,
  output logic                                      err_last,
  output logic                                      err_cfg
);

  localparam int unsigned K     = KERNEL_SIZE;
  localparam int unsigned CntW  = cnt_width(MAX_WIDTH);
  // Row counter needs headroom for the padded flush rows beyond the frame.
  localparam int unsigned RowW  = CntW + 1;
  localparam int unsigned AddrW = addr_width(MAX_WIDTH);
  localparam int unsigned P     = K / 2;

  state_t                state_q, state_d;
  logic [CntW-1:0]       width_q, height_q;
  logic [CntW-1:0]       col_q;
  logic [RowW-1:0]       row_q;
  logic                  out_valid_q, out_last_q;
  logic                  err_last_q, err_cfg_q;
  logic [DATA_WIDTH-1:0] win_q   [K][K];
  logic [DATA_WIDTH-1:0] col_vec [K];
  logic [DATA_WIDTH-1:0] lb_rd   [K-1];
  logic [DATA_WIDTH-1:0] lb_wr   [K-1];
  logic [DATA_WIDTH-1:0] in_data;

  logic cfg_ok, start_ok, out_free, accept, advance;
  logic col_last, is_final_pix, fill_done, emit, emit_last;

  assign cfg_ok   = (cfg_width >= CntW'(K)) && (cfg_width <= CntW'(MAX_WIDTH)) &&
                    (cfg_height >= CntW'(K));
  assign start_ok = (state_q == StIdle) && cfg_start && cfg_ok;

  // Upstream may only advance when the output register can take a new window.
  assign out_free     = !out_valid_q || m_axis_ready;
  assign s_axis_ready = ((state_q == StFill) || (state_q == StStream)) && out_free;
  assign accept       = s_axis_valid && s_axis_ready;

  assign col_last     = (col_q == width_q - CntW'(1));
  assign is_final_pix = col_last && (row_q == {1'b0, height_q} - RowW'(1));

`ifdef CONV_WIN_ZERO_PAD_EN
  logic            step;
  logic [CntW-1:0] cen_col_q;
  logic [RowW-1:0] cen_row_q;

  // Flush walks virtual zero pixels until the last centred window has been produced.
  assign step      = (state_q == StFlush) && (!out_valid_q || (m_axis_ready && !out_last_q));
  assign advance   = accept || step;
  assign in_data   = accept ? s_axis_data : '0;
  assign fill_done = accept && (row_q == RowW'(P)) && (col_q == CntW'(P - 1));
  assign emit      = advance && (state_q != StFill);
  assign emit_last = step && (row_q == {1'b0, height_q} + RowW'(P)) &&
                     (col_q == CntW'(P - 1));

  // Centre of the window being loaded lags the newest position by P lines and P columns.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      cen_col_q <= '0;
      cen_row_q <= '0;
    end else if (emit) begin
      if (col_q >= CntW'(P)) begin
        cen_col_q <= col_q - CntW'(P);
        cen_row_q <= row_q - RowW'(P);
      end else begin
        cen_col_q <= col_q + width_q - CntW'(P);
        cen_row_q <= row_q - RowW'(P + 1);
      end
    end
  end

  // Window bus with taps outside the frame forced to zero.
  always_comb begin
    int tc;
    int tr;
    m_axis_window = '0;
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K; c++) begin
        tc = int'(cen_col_q) + int'(c) - int'(P);
        tr = int'(cen_row_q) + int'(r) - int'(P);
        if ((tc >= 0) && (tc < int'(width_q)) && (tr >= 0) && (tr < int'(height_q))) begin
          m_axis_window[tap_lsb(r, c, K, DATA_WIDTH) +: DATA_WIDTH] = win_q[r][c];
        end
      end
    end
  end
`else
  assign advance   = accept;
  assign in_data   = s_axis_data;
  assign fill_done = accept && (row_q == RowW'(K - 1)) && (col_q == CntW'(K - 2));
  assign emit      = accept && (row_q >= RowW'(K - 1)) && (col_q >= CntW'(K - 1));
  assign emit_last = accept && is_final_pix;

  // Window bus straight from the shift registers; they only move when the output is free.
  always_comb begin
    m_axis_window = '0;
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K; c++) begin
        m_axis_window[tap_lsb(r, c, K, DATA_WIDTH) +: DATA_WIDTH] = win_q[r][c];
      end
    end
  end
`endif

  // Line buffers cascade: each one stores the line the previous one just evicted.
  always_comb begin
    lb_wr[0] = in_data;
    for (int unsigned i = 1; i < K - 1; i++) begin
      lb_wr[i] = lb_rd[i-1];
    end
    col_vec[K-1] = in_data;
    for (int unsigned i = 0; i < K - 1; i++) begin
      col_vec[K-2-i] = lb_rd[i];
    end
  end

  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    conv_line_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (MAX_WIDTH),
      .ADDR_WIDTH (AddrW)
    ) u_line_buffer (
      .clk     (axi_clk),
      .wr_en   (advance),
      .addr    (col_q[AddrW-1:0]),
      .wr_data (lb_wr[i]),
      .rd_data (lb_rd[i])
    );
  end

  // Frame sequencing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_ok) state_d = StFill;
      StFill:   if (fill_done) state_d = StStream;
      StStream: if (accept && is_final_pix) state_d = StFlush;
      StFlush:  if (out_valid_q && m_axis_ready && out_last_q) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State, frame size, raster position and sticky error flags.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q    <= StIdle;
      width_q    <= '0;
      height_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      err_last_q <= 1'b0;
      err_cfg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        width_q  <= cfg_width;
        height_q <= cfg_height;
        col_q    <= '0;
        row_q    <= '0;
      end else if (advance) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_q + RowW'(1);
        end else begin
          col_q <= col_q + CntW'(1);
        end
      end
      if (start_ok) begin
        err_last_q <= 1'b0;
        err_cfg_q  <= 1'b0;
      end else begin
        if ((state_q == StIdle) && cfg_start) err_cfg_q <= 1'b1;
        if (accept && (s_axis_last != is_final_pix)) err_last_q <= 1'b1;
      end
    end
  end

  // Window shift registers and output handshake register.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int unsigned r = 0; r < K; r++) begin
        for (int unsigned c = 0; c < K; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      if (advance) begin
        for (int unsigned r = 0; r < K; r++) begin
          for (int unsigned c = 0; c < K - 1; c++) begin
            win_q[r][c] <= win_q[r][c+1];
          end
          win_q[r][K-1] <= col_vec[r];
        end
      end
      if (emit) begin
        out_valid_q <= 1'b1;
        out_last_q  <= emit_last;
      end else if (m_axis_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign m_axis_valid = out_valid_q;
  assign m_axis_last  = out_last_q;
  assign busy         = (state_q != StIdle);
  assign err_last     = err_last_q;
  assign err_cfg      = err_cfg_q;

endmodule

// File: tb/tb_conv_window_streamer.sv
// Directed bench for conv_window_streamer (K=3, 32-bit pixels, pixel = linear index).
module tb_conv_window_streamer;

  localparam int DW   = 32;
  localparam int K    = 3;
  localparam int MAXW = 1024;
  localparam int CW   = $clog2(MAXW + 1);
  localparam int WINW = K * K * DW;

  logic            axi_clk = 1'b0;
  logic            axi_reset_n = 1'b0;
  logic [CW-1:0]   cfg_width = '0;
  logic [CW-1:0]   cfg_height = '0;
  logic            cfg_start = 1'b0;
  logic            s_axis_valid = 1'b0;
  logic            s_axis_ready;
  logic [DW-1:0]   s_axis_data = '0;
  logic            s_axis_last = 1'b0;
  logic            m_axis_valid;
  logic            m_axis_ready = 1'b1;
  logic [WINW-1:0] m_axis_window;
  logic            m_axis_last;
  logic            busy;
  logic            err_last;
  logic            err_cfg;

  int n_checks = 0;
  int n_pass = 0;

  conv_window_streamer #(
    .DATA_WIDTH  (DW),
    .KERNEL_SIZE (K),
    .MAX_WIDTH   (MAXW)
  ) dut (
    .axi_clk       (axi_clk),
    .axi_reset_n   (axi_reset_n),
    .cfg_width     (cfg_width),
    .cfg_height    (cfg_height),
    .cfg_start     (cfg_start),
    .s_axis_valid  (s_axis_valid),
    .s_axis_ready  (s_axis_ready),
    .s_axis_data   (s_axis_data),
    .s_axis_last   (s_axis_last),
    .m_axis_valid  (m_axis_valid),
    .m_axis_ready  (m_axis_ready),
    .m_axis_window (m_axis_window),
    .m_axis_last   (m_axis_last),
    .busy          (busy),
    .err_last      (err_last),
    .err_cfg       (err_cfg)
  );

  always #5 axi_clk = ~axi_clk;

  function automatic int n_windows(input int w, input int h);
`ifdef CONV_WIN_ZERO_PAD_EN
    return w * h;
`else
    return (w - K + 1) * (h - K + 1);
`endif
  endfunction

  // Pixel index whose acceptance completes the first window.
  function automatic int first_pix(input int w);
`ifdef CONV_WIN_ZERO_PAD_EN
    return (K / 2) * w + K / 2;
`else
    return (K - 1) * w + K - 1;
`endif
  endfunction

  function automatic logic [WINW-1:0] exp_win(input int w, input int h, input int idx);
    logic [WINW-1:0] v;
    int val;
    int tr;
    int tc;
    v = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
`ifdef CONV_WIN_ZERO_PAD_EN
        tr = idx / w + r - K / 2;
        tc = idx % w + c - K / 2;
        val = (tr >= 0 && tr < h && tc >= 0 && tc < w) ? tr * w + tc : 0;
`else
        tr = idx / (w - K + 1) + r;
        tc = idx % (w - K + 1) + c;
        val = (tr < h) ? tr * w + tc : -1;
`endif
        v[(r * K + c) * DW +: DW] = DW'(val);
      end
    end
    return v;
  endfunction

  task automatic test_reset();
    axi_reset_n = 1'b0;
    repeat (2) @(negedge axi_clk);
    n_checks++; if (s_axis_ready !== 1'b0) $display("FAIL reset_s_ready got %b want 0", s_axis_ready); else n_pass++;
    n_checks++; if (m_axis_valid !== 1'b0) $display("FAIL reset_m_valid got %b want 0", m_axis_valid); else n_pass++;
    n_checks++; if (m_axis_last !== 1'b0) $display("FAIL reset_m_last got %b want 0", m_axis_last); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (err_last !== 1'b0) $display("FAIL reset_err_last got %b want 0", err_last); else n_pass++;
    n_checks++; if (err_cfg !== 1'b0) $display("FAIL reset_err_cfg got %b want 0", err_cfg); else n_pass++;
    n_checks++; if (m_axis_window !== '0) $display("FAIL reset_window got %h want 0", m_axis_window); else n_pass++;
    axi_reset_n = 1'b1;
    @(negedge axi_clk);
  endtask

  task automatic test_bad_cfg();
    cfg_width = CW'(2);
    cfg_height = CW'(8);
    s_axis_valid = 1'b1;
    m_axis_ready = 1'b1;
    cfg_start = 1'b1;
    @(negedge axi_clk);
    cfg_start = 1'b0;
    #1;
    n_checks++; if (err_cfg !== 1'b1) $display("FAIL bad_cfg_err got %b want 1", err_cfg); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL bad_cfg_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (s_axis_ready !== 1'b0) $display("FAIL bad_cfg_ready got %b want 0", s_axis_ready); else n_pass++;
    s_axis_valid = 1'b0;
    @(negedge axi_clk);
  endtask

  // Runs one frame: w x h pixels, optional 50% output back-pressure, s_axis_last on pixel
  // last_at, optional stray cfg_start mid-frame; checks every window, stalls and end state.
  task automatic run_frame(input string name, input int w, input int h, input bit toggle,
                           input int last_at, input bit poke_start, input bit exp_err_last);
    int pix = 0;
    int widx = 0;
    int cyc = 0;
    int acc_cyc = -1;
    int first_cyc = -1;
    int nwin;
    bit have_held = 1'b0;
    logic [WINW-1:0] held_win = '0;
    logic held_last = 1'b0;
    nwin = n_windows(w, h);
    cfg_width = CW'(w);
    cfg_height = CW'(h);
    cfg_start = 1'b1;
    @(negedge axi_clk);
    cfg_start = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL %s_armed got %b want 1", name, busy); else n_pass++;
    n_checks++; if (err_cfg !== 1'b0) $display("FAIL %s_err_cfg_clear got %b want 0", name, err_cfg); else n_pass++;
    while (!(widx == nwin && busy == 1'b0) && cyc < 2000) begin
      s_axis_valid = (pix < w * h);
      s_axis_data = DW'(pix);
      s_axis_last = (pix == last_at);
      m_axis_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      if (poke_start && cyc == 10) begin
        cfg_width = CW'(4);
        cfg_height = CW'(4);
        cfg_start = 1'b1;
      end else begin
        cfg_start = 1'b0;
      end
      #1;
      if (m_axis_valid) begin
        if (have_held) begin
          n_checks++;
          if (m_axis_window !== held_win || m_axis_last !== held_last)
            $display("FAIL %s_stall_hold idx %0d got %h/%b want %h/%b", name, widx,
                     m_axis_window, m_axis_last, held_win, held_last);
          else n_pass++;
        end
        if (m_axis_ready) begin
          if (widx == 0) first_cyc = cyc;
          n_checks++;
          if (m_axis_window !== exp_win(w, h, widx))
            $display("FAIL %s_window idx %0d got %h want %h", name, widx, m_axis_window,
                     exp_win(w, h, widx));
          else n_pass++;
          n_checks++;
          if (m_axis_last !== (widx == nwin - 1))
            $display("FAIL %s_last idx %0d got %b want %b", name, widx, m_axis_last,
                     (widx == nwin - 1));
          else n_pass++;
          widx++;
          have_held = 1'b0;
        end else begin
          held_win = m_axis_window;
          held_last = m_axis_last;
          have_held = 1'b1;
        end
      end
      if (s_axis_valid && s_axis_ready) begin
        if (pix == first_pix(w)) acc_cyc = cyc;
        pix++;
      end
      cyc++;
      @(negedge axi_clk);
    end
    s_axis_valid = 1'b0;
    s_axis_last = 1'b0;
    cfg_start = 1'b0;
    m_axis_ready = 1'b1;
    #1;
    n_checks++; if (cyc >= 2000) $display("FAIL %s_timeout cycles %0d limit 2000", name, cyc); else n_pass++;
    n_checks++; if (widx != nwin) $display("FAIL %s_count got %0d want %0d", name, widx, nwin); else n_pass++;
    n_checks++; if (pix != w * h) $display("FAIL %s_pixels got %0d want %0d", name, pix, w * h); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL %s_busy_end got %b want 0", name, busy); else n_pass++;
    n_checks++; if (m_axis_valid !== 1'b0) $display("FAIL %s_valid_end got %b want 0", name, m_axis_valid); else n_pass++;
    n_checks++; if (err_last !== exp_err_last) $display("FAIL %s_err_last got %b want %b", name, err_last, exp_err_last); else n_pass++;
    if (!toggle) begin
      n_checks++;
      if (first_cyc != acc_cyc + 1)
        $display("FAIL %s_latency got %0d want %0d", name, first_cyc - acc_cyc, 1);
      else n_pass++;
    end
    @(negedge axi_clk);
  endtask

  task automatic test_reset_mid();
    int acc = 0;
    int cyc = 0;
    bit stale = 1'b0;
    cfg_width = CW'(8);
    cfg_height = CW'(8);
    cfg_start = 1'b1;
    @(negedge axi_clk);
    cfg_start = 1'b0;
    m_axis_ready = 1'b1;
    while (acc < 20 && cyc < 200) begin
      s_axis_valid = 1'b1;
      s_axis_data = DW'(acc);
      #1;
      if (s_axis_valid && s_axis_ready) acc++;
      cyc++;
      @(negedge axi_clk);
    end
    s_axis_valid = 1'b0;
    n_checks++; if (acc != 20) $display("FAIL mid_feed got %0d want 20", acc); else n_pass++;
    axi_reset_n = 1'b0;
    #1;
    n_checks++; if (m_axis_valid !== 1'b0) $display("FAIL mid_rst_valid got %b want 0", m_axis_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (s_axis_ready !== 1'b0) $display("FAIL mid_rst_ready got %b want 0", s_axis_ready); else n_pass++;
    n_checks++; if (m_axis_window !== '0) $display("FAIL mid_rst_window got %h want 0", m_axis_window); else n_pass++;
    n_checks++; if (m_axis_last !== 1'b0) $display("FAIL mid_rst_last got %b want 0", m_axis_last); else n_pass++;
    @(negedge axi_clk);
    axi_reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge axi_clk);
      if (m_axis_valid !== 1'b0 || busy !== 1'b0) stale = 1'b1;
    end
    n_checks++; if (stale) $display("FAIL mid_stale got 1 want 0"); else n_pass++;
    run_frame("after_reset", 8, 8, 1'b0, 63, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_bad_cfg();
    run_frame("basic", 8, 8, 1'b0, 63, 1'b0, 1'b0);
    run_frame("last_err", 8, 8, 1'b0, 40, 1'b0, 1'b1);
    run_frame("backpressure", 8, 8, 1'b1, 63, 1'b1, 1'b0);
    test_reset_mid();
`ifdef CONV_WIN_ZERO_PAD_EN
    run_frame("pad4x4", 4, 4, 1'b0, 15, 1'b0, 1'b0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
